// File: rtl/pin_handshake_receiver.sv
// rtl/pin_handshake_receiver.sv - 4-phase pin receiver into a stream FIFO; PIN_RX_PARITY_EN adds even-parity checking
module pin_handshake_receiver #(
    parameter int bits       = 16,
    parameter int depth_log2 = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [bits-1:0] pins_data,
    input  logic            pins_req,
    output logic            pins_ack,
`ifdef PIN_RX_PARITY_EN
    input  logic            pins_parity,
    output logic            parity_err,
`endif
    output logic [bits-1:0] out1,
    output logic            out1_stb,
    input  logic            out1_ack
);
    localparam int DEPTH = 1 << depth_log2;
    localparam logic [depth_log2:0] FULL_COUNT = (depth_log2 + 1)'(DEPTH);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        CAPTURE  = 2'd1,
        WAIT_LOW = 2'd2
    } state_t;

    state_t                r_state;
    state_t                w_state_next;
    logic                  r_req_meta;
    logic                  r_req_s;
    logic                  r_ack;
    logic                  w_ack_next;
    logic                  w_capture;
    logic                  w_word_ok;
    logic                  w_push;
    logic                  w_pop;
    logic                  w_full;
    logic [bits-1:0]       r_mem [DEPTH];
    logic [depth_log2-1:0] r_wr_ptr;
    logic [depth_log2-1:0] r_rd_ptr;
    logic [depth_log2:0]   r_count;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_req_meta <= 1'b0;
            r_req_s    <= 1'b0;
        end else begin
            r_req_meta <= pins_req;
            r_req_s    <= r_req_meta;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
            r_ack   <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_ack   <= w_ack_next;
        end
    end

    // A req that has already vanished by CAPTURE is a glitch: back to IDLE without ack or push.
    always_comb begin
        w_state_next = r_state;
        w_ack_next   = r_ack;
        w_capture    = 1'b0;
        case (r_state)
            IDLE: begin
                if (r_req_s && !w_full) begin
                    w_state_next = CAPTURE;
                end
            end
            CAPTURE: begin
                if (r_req_s) begin
                    w_capture    = 1'b1;
                    w_ack_next   = 1'b1;
                    w_state_next = WAIT_LOW;
                end else begin
                    w_state_next = IDLE;
                end
            end
            WAIT_LOW: begin
                if (!r_req_s) begin
                    w_ack_next   = 1'b0;
                    w_state_next = IDLE;
                end
            end
            default: begin
                w_ack_next   = 1'b0;
                w_state_next = IDLE;
            end
        endcase
    end

`ifdef PIN_RX_PARITY_EN
    logic r_parity_err;

    assign w_word_ok = ~(^{pins_data, pins_parity});

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_parity_err <= 1'b0;
        end else if (w_capture && !w_word_ok) begin
            r_parity_err <= 1'b1;
        end
    end

    assign parity_err = r_parity_err;
`else
    assign w_word_ok = 1'b1;
`endif

    // Only the FSM pushes and it enters CAPTURE only when not full, so a push never overflows.
    assign w_push = w_capture && w_word_ok;
    assign w_pop  = out1_stb && out1_ack;
    assign w_full = (r_count == FULL_COUNT);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= pins_data;
                r_wr_ptr        <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + 1'b1;
            end else if (!w_push && w_pop) begin
                r_count <= r_count - 1'b1;
            end
        end
    end

    assign pins_ack = r_ack;
    assign out1     = r_mem[r_rd_ptr];
    assign out1_stb = (r_count != '0);

endmodule

// File: tb/tb_pin_handshake_receiver.sv
// tb/tb_pin_handshake_receiver.sv - randomized bench for pin_handshake_receiver against a queue reference model
module tb_pin_handshake_receiver;
    localparam int BITS = 16;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic [BITS-1:0] pins_data = '0;
    logic            pins_req = 1'b0;
    logic            pins_ack;
    logic [BITS-1:0] out1;
    logic            out1_stb;
    logic            out1_ack = 1'b0;
`ifdef PIN_RX_PARITY_EN
    logic            pins_parity = 1'b0;
    logic            parity_err;
`endif

    int              n_checks = 0;
    int              n_fail = 0;
    logic [BITS-1:0] exp_q[$];
    int              ack_mode = 0;
    int              n_xfer = 0;
    int              n_stb = 0;
    int              x0;
    int              s0;
    bit              seen;

    pin_handshake_receiver #(.bits(BITS), .depth_log2(2)) dut (
        .clk        (clk),
        .rst        (rst),
        .pins_data  (pins_data),
        .pins_req   (pins_req),
        .pins_ack   (pins_ack),
`ifdef PIN_RX_PARITY_EN
        .pins_parity(pins_parity),
        .parity_err (parity_err),
`endif
        .out1       (out1),
        .out1_stb   (out1_stb),
        .out1_ack   (out1_ack)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Consumer: owns out1_ack; a word transfers on the next rising edge iff stb and ack are both high here.
    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                case (ack_mode)
                    1:       out1_ack = 1'b1;
                    2:       out1_ack = 1'($urandom_range(0, 1));
                    default: out1_ack = 1'b0;
                endcase
                if (out1_stb) n_stb++;
                if (out1_stb && out1_ack) begin
                    n_xfer++;
                    if (exp_q.size() == 0) check_eq("unexpected_word", exp_q.size(), 1);
                    else check_eq("out1_order", out1, exp_q.pop_front());
                end
            end
        end
    end

    task automatic raise_req(input logic [BITS-1:0] d, input bit corrupt);
        @(negedge clk);
        pins_data = d;
`ifdef PIN_RX_PARITY_EN
        pins_parity = (^d) ^ corrupt;
`endif
        pins_req = 1'b1;
        if (!corrupt) exp_q.push_back(d);
    endtask

    task automatic wait_ack(input logic lvl, input string tag, output int cyc);
        cyc = 0;
        while (pins_ack !== lvl && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
        check_eq(tag, pins_ack, lvl);
    endtask

    task automatic send_word(input logic [BITS-1:0] d, input bit corrupt, input bit chk_lat);
        int cyc;
        raise_req(d, corrupt);
        wait_ack(1'b1, "ack_rise", cyc);
        if (chk_lat) check_eq("ack_rise_latency", cyc, 4);
        pins_req = 1'b0;
        wait_ack(1'b0, "ack_fall", cyc);
        if (chk_lat) check_eq("ack_fall_latency", cyc, 3);
    endtask

    task automatic wait_drain();
        int cyc;
        cyc = 0;
        while (exp_q.size() != 0 && cyc < 400) begin
            @(negedge clk);
            cyc++;
        end
        check_eq("drain_empty", exp_q.size(), 0);
        repeat (3) @(negedge clk);
    endtask

    initial begin
        int cyc;
        repeat (3) @(negedge clk);
        check_eq("reset_ack", pins_ack, 0);
        check_eq("reset_stb", out1_stb, 0);
        check_eq("reset_out1", out1, 0);
`ifdef PIN_RX_PARITY_EN
        check_eq("reset_parity_err", parity_err, 0);
`endif
        rst = 1'b1;
        @(negedge clk);
        check_eq("post_reset_stb", out1_stb, 0);

        // Single word, consumer always ready
        ack_mode = 1;
        x0 = n_xfer; s0 = n_stb;
        send_word(16'h1234, 1'b0, 1'b1);
        wait_drain();
        check_eq("single_xfers", n_xfer - x0, 1);
        check_eq("single_stb_cycles", n_stb - s0, 1);

        // Fill to depth with consumer stalled, fifth req must stall
        ack_mode = 0;
        x0 = n_xfer;
        for (int i = 1; i <= 4; i++) send_word(BITS'(i), 1'b0, 1'b1);
        raise_req(16'h0005, 1'b0);
        repeat (20) @(negedge clk);
        check_eq("stall_no_ack", pins_ack, 0);
        check_eq("stall_stb", out1_stb, 1);
        check_eq("stall_head", out1, 16'h0001);
        ack_mode = 1;
        wait_ack(1'b1, "stall_release_ack", cyc);
        pins_req = 1'b0;
        wait_ack(1'b0, "stall_ack_fall", cyc);
        wait_drain();
        check_eq("fill_xfers", n_xfer - x0, 5);

        // Back-to-back words with continuous accept: each word visible one cycle only
        ack_mode = 1;
        s0 = n_stb;
        send_word(16'hAAAA, 1'b0, 1'b1);
        send_word(16'h5555, 1'b0, 1'b1);
        wait_drain();
        check_eq("simul_stb_cycles", n_stb - s0, 2);

        // One-clock req glitch
        s0 = n_stb; seen = 1'b0;
        @(negedge clk); pins_req = 1'b1;
        @(negedge clk); pins_req = 1'b0;
        repeat (10) begin
            @(negedge clk);
            if (pins_ack) seen = 1'b1;
        end
        check_eq("glitch_no_ack", seen, 0);
        check_eq("glitch_no_stb", n_stb - s0, 0);

        // Reset with three words buffered and a fourth mid-handshake
        ack_mode = 0;
        for (int i = 0; i < 3; i++) send_word(BITS'(16'h0100 + i), 1'b0, 1'b0);
        raise_req(16'h4444, 1'b0);
        wait_ack(1'b1, "pre_reset_ack", cyc);
        check_eq("pre_reset_stb", out1_stb, 1);
        #2 rst = 1'b0;
        #1;
        check_eq("midreset_ack", pins_ack, 0);
        check_eq("midreset_stb", out1_stb, 0);
        check_eq("midreset_out1", out1, 0);
        exp_q.delete();
        pins_req = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        ack_mode = 1;
        x0 = n_xfer;
        send_word(16'hBEEF, 1'b0, 1'b1);
        wait_drain();
        check_eq("post_reset_xfers", n_xfer - x0, 1);

`ifdef PIN_RX_PARITY_EN
        x0 = n_xfer;
        send_word(16'h0001, 1'b1, 1'b1);
        repeat (3) @(negedge clk);
        check_eq("parity_err_set", parity_err, 1);
        send_word(16'h0003, 1'b0, 1'b1);
        wait_drain();
        check_eq("parity_err_sticky", parity_err, 1);
        check_eq("parity_xfers", n_xfer - x0, 1);
`endif

        // Random traffic with a randomly stalling consumer
        ack_mode = 2;
        x0 = n_xfer;
        for (int i = 0; i < 40; i++) begin
            repeat ($urandom_range(0, 3)) @(negedge clk);
            send_word(BITS'($urandom), 1'b0, 1'b0);
        end
        ack_mode = 1;
        wait_drain();
        check_eq("random_xfers", n_xfer - x0, 40);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
